// File: rtl/dmem_result_checker.sv
// Runs the CPU for a bounded number of cycles, or until its fetch address stalls,
// then scans dmem word by word against an expected-value source and reports the result.
module dmem_result_checker #(
  parameter int unsigned RUN_CYCLES  = 1000,
  parameter int unsigned NWORDS      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned HALT_WINDOW = 0,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned IDX_W       = $clog2(NWORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      iaddr,
  output logic [31:0]      chk_addr,
  input  logic [31:0]      chk_rdata,
  output logic [IDX_W-1:0] exp_idx,
  input  logic [31:0]      exp_data,
  output logic             hold_cpu,
  output logic             done,
  output logic             pass,
  output logic             halted,
  output logic [CNT_W-1:0] fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [31:0]      cycles_run
);

  // state | meaning
  // RUN   | CPU free-running; count cycles, watch iaddr for a halt
  // SCAN  | CPU held; compare one dmem word per cycle
  // DONE  | result registered and frozen until reset
  typedef enum logic [1:0] {ST_RUN, ST_SCAN, ST_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NWORDS - 1);
  localparam logic [IDX_W-1:0] NONE_IDX  = IDX_W'(NWORDS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [31:0]      RUN_LAST  = 32'(RUN_CYCLES - 1);
  localparam logic [31:0]      HALT_LAST = 32'(HALT_WINDOW - 1);

  state_t           state_q, state_d;
  logic [31:0]      cycles_run_q, cycles_run_d;
  logic [31:0]      stable_cnt_q, stable_cnt_d;
  logic [31:0]      iaddr_prev_q, iaddr_prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic [IDX_W-1:0] first_fail_q, first_fail_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             halted_q, halted_d;

  logic iaddr_same;
  logic halt_hit;
  logic mismatch;

  always_comb begin
    state_d      = state_q;
    cycles_run_d = cycles_run_q;
    stable_cnt_d = stable_cnt_q;
    iaddr_prev_d = iaddr_prev_q;
    prev_vld_d   = prev_vld_q;
    idx_d        = idx_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    done_d       = done_q;
    pass_d       = pass_q;
    halted_d     = halted_q;

    // RUN cycle 0 has no previous fetch address, so it always counts as a change
    iaddr_same = prev_vld_q && (iaddr == iaddr_prev_q);
    halt_hit   = (HALT_WINDOW != 0) && iaddr_same && (stable_cnt_q == HALT_LAST);
    // Case inequality so that undriven/unknown data can never pass as a match
    mismatch   = (chk_rdata !== exp_data);

    case (state_q)
      ST_RUN: begin
        cycles_run_d = cycles_run_q + 32'd1;
        iaddr_prev_d = iaddr;
        prev_vld_d   = 1'b1;
        stable_cnt_d = iaddr_same ? stable_cnt_q + 32'd1 : 32'd0;
        if (halt_hit || (cycles_run_q == RUN_LAST)) begin
          state_d  = ST_SCAN;
          halted_d = halt_hit;
        end
      end
      ST_SCAN: begin
        if (mismatch) begin
          if (fail_count_q != CNT_MAX) fail_count_d = fail_count_q + 1'b1;
          if (first_fail_q == NONE_IDX) first_fail_d = idx_q;
        end
        if (idx_q == LAST_IDX) state_d = ST_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
        pass_d = (fail_count_q == '0);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cycles_run_q <= '0;
      stable_cnt_q <= '0;
      iaddr_prev_q <= '0;
      prev_vld_q   <= 1'b0;
      idx_q        <= '0;
      fail_count_q <= '0;
      first_fail_q <= NONE_IDX;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycles_run_q <= cycles_run_d;
      stable_cnt_q <= stable_cnt_d;
      iaddr_prev_q <= iaddr_prev_d;
      prev_vld_q   <= prev_vld_d;
      idx_q        <= idx_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      halted_q     <= halted_d;
    end
  end

  assign hold_cpu       = (state_q != ST_RUN);
  assign chk_addr       = (state_q == ST_SCAN) ? BASE_ADDR + (32'(idx_q) << 2) : 32'd0;
  assign exp_idx        = (state_q == ST_SCAN) ? idx_q : '0;
  assign done           = done_q;
  assign pass           = pass_q;
  assign halted         = halted_q;
  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_q;
  assign cycles_run     = cycles_run_q;

endmodule

// File: tb/tb_dmem_result_checker.sv
// Randomized scoreboard bench for dmem_result_checker: the driver predicts every
// observable step of each run and queues it; a negedge monitor compares on schedule.
module tb_dmem_result_checker;
  localparam int RC = 40;
  localparam int N  = 8;
  localparam int HW = 6;
  localparam int CW = 3;
  localparam int IW = $clog2(N + 1);
  localparam int AW = $clog2(N);
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int FC_MAX = (1 << CW) - 1;

  localparam int K_RST = 0, K_RUNEND = 1, K_SCAN = 2, K_PRE = 3, K_FINAL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   iaddr = 32'd0;
  logic [31:0]   chk_addr, chk_rdata, exp_data, cycles_run;
  logic [IW-1:0] exp_idx, first_fail_idx;
  logic          hold_cpu, done, pass, halted;
  logic [CW-1:0] fail_count;

  logic [31:0] mem  [N];
  logic [31:0] expv [N];

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] addr;
    int          idx;
    bit          hl;
    int          fc;
    int          ffi;
    int          cr;
    bit          ps;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   gcyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  wire [31:0] off = chk_addr - BASE;
  assign chk_rdata = (off < 32'(4 * N)) ? mem[off[AW+1:2]] : 32'hDEAD_BEEF;
  assign exp_data  = expv[exp_idx[AW-1:0]];

  dmem_result_checker #(
    .RUN_CYCLES(RC), .NWORDS(N), .BASE_ADDR(BASE), .HALT_WINDOW(HW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .iaddr(iaddr),
    .chk_addr(chk_addr), .chk_rdata(chk_rdata),
    .exp_idx(exp_idx), .exp_data(exp_data),
    .hold_cpu(hold_cpu), .done(done), .pass(pass), .halted(halted),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx), .cycles_run(cycles_run)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expct);
    n_vec++;
    if (act !== expct) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expct, gcyc);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < gcyc) begin
      n_vec++;
      n_fail++;
      $display("FAIL missed_check: kind %0d due at cycle %0d, now %0d", q[0].kind, q[0].cyc, gcyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == gcyc) begin
      e_mon = q.pop_front();
      case (e_mon.kind)
        K_RST: begin
          chk("rst_done", 32'(done), 0);
          chk("rst_pass", 32'(pass), 0);
          chk("rst_halted", 32'(halted), 0);
          chk("rst_fail_count", 32'(fail_count), 0);
          chk("rst_first_fail_idx", 32'(first_fail_idx), N);
          chk("rst_cycles_run", cycles_run, 0);
          chk("rst_hold_cpu", 32'(hold_cpu), 0);
          chk("rst_chk_addr", chk_addr, 0);
          chk("rst_exp_idx", 32'(exp_idx), 0);
        end
        K_RUNEND: begin
          chk("run_hold_cpu", 32'(hold_cpu), 0);
          chk("run_halted", 32'(halted), 0);
          chk("run_cycles_run", cycles_run, 32'(e_mon.cr));
        end
        K_SCAN: begin
          chk("scan_hold_cpu", 32'(hold_cpu), 1);
          chk("scan_chk_addr", chk_addr, e_mon.addr);
          chk("scan_exp_idx", 32'(exp_idx), 32'(e_mon.idx));
          chk("scan_done", 32'(done), 0);
        end
        K_PRE: begin
          chk("pre_done", 32'(done), 0);
          chk("pre_hold_cpu", 32'(hold_cpu), 1);
        end
        default: begin
          chk("fin_done", 32'(done), 1);
          chk("fin_pass", 32'(pass), 32'(e_mon.ps));
          chk("fin_halted", 32'(halted), 32'(e_mon.hl));
          chk("fin_fail_count", 32'(fail_count), 32'(e_mon.fc));
          chk("fin_first_fail_idx", 32'(first_fail_idx), 32'(e_mon.ffi));
          chk("fin_cycles_run", cycles_run, 32'(e_mon.cr));
          chk("fin_hold_cpu", 32'(hold_cpu), 1);
          chk("fin_chk_addr", chk_addr, 0);
        end
      endcase
    end
  end

  task automatic push(input exp_t t, input int abort_at, input int base_g);
    if (abort_at < 0 || t.cyc <= abort_at) begin
      t.cyc = t.cyc + base_g;
      q.push_back(t);
    end
  endtask

  // smode: iaddr pattern; mmode: memory corruption; ab: 0 none, 1 reset in RUN, 2 in SCAN idx 1, 3 in DONE
  task automatic run(input int smode, input int mmode, input int ab);
    logic [31:0] seq [RC];
    int  k, e_cyc, nmis, ffi, base_g, abort_at, last_rel;
    bit  hl, all_eq;
    exp_t t;

    k = $urandom_range(5, 28);
    for (int c = 0; c < RC; c++) begin
      case (smode)
        0:       seq[c] = 32'h1000 + 32'(4 * c);
        1:       seq[c] = (c < k) ? 32'h1000 + 32'(4 * c) : 32'h1000 + 32'(4 * k);
        2:       seq[c] = (c < k) ? 32'h2000 + 32'(4 * c) : ((c == k + 3) ? 32'h80 : 32'h40);
        3:       seq[c] = (c < RC - 1 - HW) ? 32'h1000 + 32'(4 * c) : 32'hABC0;
        default: seq[c] = ($urandom_range(0, 1) == 1) ? 32'h4 : 32'h0;
      endcase
    end

    // Run ends at the first cycle closing HW consecutive unchanged fetches, else at the limit
    e_cyc = RC - 1;
    hl = 1'b0;
    for (int c = HW; c < RC; c++) begin
      all_eq = 1'b1;
      for (int j = 1; j <= HW; j++) if (seq[c - j] != seq[c]) all_eq = 1'b0;
      if (all_eq) begin
        e_cyc = c;
        hl = 1'b1;
        break;
      end
    end

    for (int i = 0; i < N; i++) begin
      mem[i]  = $urandom;
      expv[i] = mem[i];
      if (mmode == 1 && $urandom_range(0, 2) == 0) mem[i] = mem[i] ^ (32'd1 << $urandom_range(0, 31));
      if (mmode == 2) mem[i] = ~expv[i];
    end
    if (mmode == 3) expv[0] = 'x;
    if (mmode == 4) mem[$urandom_range(0, N - 1)] = 'z;

    nmis = 0;
    ffi  = N;
    for (int i = 0; i < N; i++) begin
      if (mem[i] !== expv[i]) begin
        nmis++;
        if (ffi == N) ffi = i;
      end
    end

    case (ab)
      1:       abort_at = e_cyc / 2;
      2:       abort_at = e_cyc + 2;
      3:       abort_at = e_cyc + N + 3;
      default: abort_at = -1;
    endcase
    last_rel = (abort_at >= 0) ? abort_at : e_cyc + N + 5;

    reset = 1'b1;
    @(posedge clk);
    #1;
    base_g = gcyc;
    reset  = 1'b0;
    iaddr  = seq[0];

    t = '{cyc: 0, kind: K_RST, addr: 0, idx: 0, hl: 0, fc: 0, ffi: 0, cr: 0, ps: 0};
    push(t, abort_at, base_g);
    t.cyc = e_cyc; t.kind = K_RUNEND; t.cr = e_cyc;
    push(t, abort_at, base_g);
    for (int i = 0; i < N; i++) begin
      t.cyc = e_cyc + 1 + i; t.kind = K_SCAN; t.addr = BASE + 32'(4 * i); t.idx = i;
      push(t, abort_at, base_g);
    end
    t.cyc = e_cyc + N + 1; t.kind = K_PRE;
    push(t, abort_at, base_g);
    t.kind = K_FINAL; t.hl = hl; t.fc = (nmis > FC_MAX) ? FC_MAX : nmis; t.ffi = ffi;
    t.cr = e_cyc + 1; t.ps = (nmis == 0);
    t.cyc = e_cyc + N + 2;
    push(t, abort_at, base_g);
    t.cyc = e_cyc + N + 5;
    push(t, abort_at, base_g);

    for (int c = 1; c <= last_rel; c++) begin
      @(posedge clk);
      #1;
      iaddr = (c < RC) ? seq[c] : $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    run(0, 0, 0);
    run(0, 1, 0);
    run(1, 0, 0);
    run(2, 2, 0);
    run(3, 3, 0);
    run(0, 0, 2);
    run(0, 0, 0);
    run(1, 1, 1);
    run(4, 4, 0);
    run(0, 2, 3);
    run(1, 3, 0);
    run(3, 0, 0);
    repeat (20) run($urandom_range(0, 4), $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_checks: %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
